// File: rtl/point_referee_if.sv
// point_referee_if: frame-sampled ball position in, score/serve control out.
interface point_referee_if;
    logic              fsync;
    logic signed [11:0] ball_x;
    logic              increment_score [2];
    logic              ball_reset;
    logic              serve_dir;
    logic              play_enable;
    logic [1:0]        game_point;
    logic [1:0]        match_win;
    modport master (
        input  fsync, ball_x,
        output increment_score, ball_reset, serve_dir, play_enable, game_point, match_win
    );
    modport slave (
        output fsync, ball_x,
        input  increment_score, ball_reset, serve_dir, play_enable, game_point, match_win
    );
endinterface

// File: rtl/point_referee.sv
// point_referee: rally sequencer turning ball exits into frame-aligned score increments.
module point_referee #(
    parameter int HRES         = 1280,
    parameter int SERVE_FRAMES = 60
) (
    input logic             pixel_clk,
    input logic             rst,
    point_referee_if.master bus
);
    localparam int CW = $clog2(SERVE_FRAMES + 1);
    localparam logic [CW-1:0] LAST = CW'(SERVE_FRAMES - 1);
    localparam logic signed [11:0] RIGHT = 12'(HRES);
    typedef enum logic [1:0] {DELAY, SERVE, PLAY, SCORED} state_t;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          who, who_n, hit;
    logic [3:0]    score [2];
    logic [3:0]    score_n [2];
    logic [1:0]    win_n;
    // Pulse lands on the scoreboard's fsync sampling cycle; reset discards a pending point.
    assign hit = bus.fsync && state == SCORED && !rst;
    assign bus.increment_score[0] = hit && !who;
    assign bus.increment_score[1] = hit && who;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        who_n   = who;
        case (state)
            DELAY:
                if (bus.fsync) begin
                    if (cnt == LAST) begin
                        state_n = SERVE;
                        cnt_n   = '0;
                    end else cnt_n = cnt + 1'b1;
                end
            SERVE: state_n = PLAY;
            PLAY:
                if (bus.fsync && bus.ball_x >= RIGHT) begin
                    state_n = SCORED;
                    who_n   = 1'b0;
                end else if (bus.fsync && bus.ball_x[11]) begin
                    state_n = SCORED;
                    who_n   = 1'b1;
                end
            SCORED:
                if (bus.fsync) begin
                    state_n = DELAY;
                    cnt_n   = '0;
                end
            default: state_n = DELAY;
        endcase
    end
    always_comb begin
        score_n = score;
        win_n   = '0;
        if (hit) begin
            if (score[who] == 4'd9) begin
                score_n[0] = '0;
                score_n[1] = '0;
                win_n[who] = 1'b1;
            end else score_n[who] = score[who] + 4'd1;
        end
    end
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state           <= DELAY;
            cnt             <= '0;
            who             <= 1'b0;
            score           <= '{default: '0};
            bus.ball_reset  <= 1'b0;
            bus.serve_dir   <= 1'b0;
            bus.play_enable <= 1'b0;
            bus.game_point  <= '0;
            bus.match_win   <= '0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            who             <= who_n;
            score           <= score_n;
            bus.ball_reset  <= state_n == SERVE;
            bus.play_enable <= state_n == PLAY;
            bus.game_point  <= {score_n[1] == 4'd9, score_n[0] == 4'd9};
            bus.match_win   <= win_n;
            if (hit) bus.serve_dir <= !who;
        end
    end
endmodule

// File: tb/tb_point_referee.sv
// tb_point_referee: scoreboard bench for rally sequencing, score pulses and the score mirror.
module tb_point_referee;
    logic       pixel_clk = 1'b0;
    logic       rst = 1'b1;
    int         n_tests = 0;
    int         n_fail = 0;
    bit         mon_on = 1'b0;
    int         exp_q [$];
    int         m_score [2] = '{0, 0};
    logic [1:0] mw_exp = 2'b00;
    logic [1:0] gp_exp;
    int         w;

    point_referee_if pif();
    point_referee #(.HRES(1280), .SERVE_FRAMES(3)) dut (
        .pixel_clk(pixel_clk),
        .rst(rst),
        .bus(pif)
    );

    always #5 pixel_clk = ~pixel_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Scoreboard: every observed increment must match the oldest expected point.
    always @(negedge pixel_clk) begin
        #2;
        if (mon_on) begin
            gp_exp = {m_score[1] == 9, m_score[0] == 9};
            n_tests++;
            if (pif.game_point !== gp_exp || pif.match_win !== mw_exp) begin
                n_fail++;
                $display("FAIL mirror: game_point=%b match_win=%b, expected %b %b", pif.game_point, pif.match_win, gp_exp, mw_exp);
            end
            mw_exp = 2'b00;
            if (rst) m_score = '{0, 0};
            else if (pif.increment_score[0] || pif.increment_score[1]) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_increment: got %b%b, expected none", pif.increment_score[1], pif.increment_score[0]);
                end else begin
                    w = exp_q.pop_front();
                    if (pif.fsync !== 1'b1 || pif.increment_score[w] !== 1'b1 || pif.increment_score[1-w] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL increment_pulse: inc=%b%b fsync=%b, expected player %0d on fsync", pif.increment_score[1], pif.increment_score[0], pif.fsync, w);
                    end
                    if (m_score[w] == 9) begin
                        m_score = '{0, 0};
                        mw_exp[w] = 1'b1;
                    end else m_score[w]++;
                end
            end
        end
    end

    task automatic step(input logic fs, input logic signed [11:0] x);
        @(negedge pixel_clk);
        pif.fsync = fs;
        pif.ball_x = x;
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 12'sd640);
        step(1'b0, 12'sd640);
        n_tests++;
        if (pif.play_enable !== 1'b0 || pif.ball_reset !== 1'b0 || pif.serve_dir !== 1'b0 || pif.game_point !== 2'b00 ||
            pif.match_win !== 2'b00 || pif.increment_score[0] !== 1'b0 || pif.increment_score[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: pe=%b br=%b sd=%b gp=%b mw=%b, expected all zero", pif.play_enable, pif.ball_reset, pif.serve_dir, pif.game_point, pif.match_win);
        end
        rst = 1'b0;
    endtask

    task automatic wait_play();
        int k = 0;
        while (pif.play_enable !== 1'b1 && k < 200) begin
            step(k % 4 == 0, 12'sd640);
            k++;
        end
        n_tests++;
        if (pif.play_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_play: play_enable=%b after %0d cycles, expected 1", pif.play_enable, k);
        end
    endtask

    task automatic play_point(input int who);
        logic signed [11:0] x;
        x = (who == 1) ? -12'sd5 : 12'sd1280;
        wait_play();
        step(1'b1, x);
        exp_q.push_back(who);
        step(1'b0, x);
        n_tests++;
        if (pif.play_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL play_drop: play_enable=%b, expected 0", pif.play_enable);
        end
        step(1'b0, 12'sd640);
        step(1'b0, 12'sd640);
        step(1'b1, 12'sd640);
        n_tests++;
        if (pif.increment_score[who] !== 1'b1 || pif.increment_score[1-who] !== 1'b0) begin
            n_fail++;
            $display("FAIL increment_frame: inc=%b%b, expected player %0d", pif.increment_score[1], pif.increment_score[0], who);
        end
        step(1'b0, 12'sd640);
        n_tests++;
        if (pif.increment_score[who] !== 1'b0 || pif.serve_dir !== (who == 0)) begin
            n_fail++;
            $display("FAIL after_increment: inc=%b serve_dir=%b, expected 0 and %b", pif.increment_score[who], pif.serve_dir, who == 0);
        end
        step(1'b0, 12'sd640);
        step(1'b0, 12'sd640);
        for (int f = 0; f < 3; f++) begin
            step(1'b1, 12'sd640);
            step(1'b0, 12'sd640);
            n_tests++;
            if (pif.ball_reset !== (f == 2)) begin
                n_fail++;
                $display("FAIL serve_latency: frame %0d ball_reset=%b, expected %b", f, pif.ball_reset, f == 2);
            end
            step(1'b0, 12'sd640);
            step(1'b0, 12'sd640);
        end
        n_tests++;
        if (exp_q.size() != 0 || pif.play_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL point_done: pending=%0d play_enable=%b, expected 0 and 1", exp_q.size(), pif.play_enable);
        end
    endtask

    task automatic test_reset();
        do_reset();
        mon_on = 1'b1;
    endtask

    task automatic test_serve();
        for (int f = 0; f < 3; f++) begin
            step(1'b1, 12'sd640);
            n_tests++;
            if (pif.ball_reset !== 1'b0 || pif.play_enable !== 1'b0) begin
                n_fail++;
                $display("FAIL delay_frame%0d: br=%b pe=%b, expected 0 0", f, pif.ball_reset, pif.play_enable);
            end
            if (f < 2) repeat (3) step(1'b0, 12'sd640);
        end
        step(1'b0, 12'sd640);
        n_tests++;
        if (pif.ball_reset !== 1'b1 || pif.play_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL serve_pulse: br=%b pe=%b, expected 1 0", pif.ball_reset, pif.play_enable);
        end
        step(1'b0, 12'sd640);
        n_tests++;
        if (pif.ball_reset !== 1'b0 || pif.play_enable !== 1'b1 || pif.serve_dir !== 1'b0) begin
            n_fail++;
            $display("FAIL play_start: br=%b pe=%b sd=%b, expected 0 1 0", pif.ball_reset, pif.play_enable, pif.serve_dir);
        end
    endtask

    task automatic test_right_exit();
        play_point(0);
    endtask

    task automatic test_left_exit();
        play_point(1);
    endtask

    task automatic test_no_point();
        logic signed [11:0] xs [3] = '{12'sd1279, 12'sd0, 12'sd640};
        wait_play();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, xs[i]);
            step(1'b0, 12'sd640);
            n_tests++;
            if (pif.play_enable !== 1'b1) begin
                n_fail++;
                $display("FAIL no_point x=%0d: play_enable=%b, expected 1", xs[i], pif.play_enable);
            end
            step(1'b0, 12'sd640);
            step(1'b0, 12'sd640);
        end
    endtask

    task automatic test_toggle();
        wait_play();
        for (int f = 0; f < 4; f++) begin
            step(1'b1, 12'sd640);
            for (int j = 0; j < 3; j++) begin
                step(1'b0, (j % 2 == 1) ? 12'sd1280 : -12'sd5);
                n_tests++;
                if (pif.play_enable !== 1'b1) begin
                    n_fail++;
                    $display("FAIL toggle f%0d j%0d: play_enable=%b, expected 1", f, j, pif.play_enable);
                end
            end
        end
    endtask

    task automatic test_match();
        do_reset();
        for (int i = 0; i < 9; i++) play_point(0);
        n_tests++;
        if (pif.game_point !== 2'b01) begin
            n_fail++;
            $display("FAIL game_point: got %b, expected 01", pif.game_point);
        end
        play_point(0);
        n_tests++;
        if (pif.game_point !== 2'b00 || pif.match_win !== 2'b00) begin
            n_fail++;
            $display("FAIL after_match: gp=%b mw=%b, expected 00 00", pif.game_point, pif.match_win);
        end
    endtask

    task automatic test_reset_mid();
        wait_play();
        step(1'b1, 12'sd1280);
        exp_q.push_back(0);
        rst = 1'b1;
        step(1'b0, 12'sd640);
        n_tests++;
        if (pif.play_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL scored_state: play_enable=%b, expected 0", pif.play_enable);
        end
        void'(exp_q.pop_back());
        rst = 1'b0;
        step(1'b0, 12'sd640);
        n_tests++;
        if (pif.play_enable !== 1'b0 || pif.serve_dir !== 1'b0 || pif.ball_reset !== 1'b0 || pif.game_point !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset_values: pe=%b sd=%b br=%b gp=%b, expected 0 0 0 00", pif.play_enable, pif.serve_dir, pif.ball_reset, pif.game_point);
        end
        step(1'b0, 12'sd640);
        step(1'b0, 12'sd640);
        for (int f = 0; f < 3; f++) begin
            step(1'b1, 12'sd640);
            n_tests++;
            if (pif.increment_score[0] !== 1'b0 || pif.increment_score[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL discarded_point f%0d: inc=%b%b, expected 00", f, pif.increment_score[1], pif.increment_score[0]);
            end
            step(1'b0, 12'sd640);
            n_tests++;
            if (pif.ball_reset !== (f == 2)) begin
                n_fail++;
                $display("FAIL reserve f%0d: ball_reset=%b, expected %b", f, pif.ball_reset, f == 2);
            end
            step(1'b0, 12'sd640);
            step(1'b0, 12'sd640);
        end
    endtask

    initial begin
        pif.fsync = 1'b0;
        pif.ball_x = 12'sd640;
        test_reset();
        test_serve();
        test_right_exit();
        test_left_exit();
        test_no_point();
        test_toggle();
        test_match();
        test_reset_mid();
        step(1'b0, 12'sd640);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_queue: %0d points outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
